// File: rtl/r200_pkg.sv
// Shared types and constants for the r200 front end.
package r200_pkg;

   localparam int unsigned XLEN    = 32;
   localparam int unsigned INSTR_W = 32;

   localparam logic [XLEN-1:0]    RESET_PC_DEFAULT = 32'h0000_0000;
   localparam logic [INSTR_W-1:0] NOP_INSTR        = 32'h0000_0013;

   // One buffered fetch result: the instruction and the PC it was fetched from.
   typedef struct packed {
      logic [XLEN-1:0]    pc;
      logic [INSTR_W-1:0] instr;
   } if_entry_t;

   // Contents of an unwritten buffer slot.
   localparam if_entry_t EMPTY_ENTRY = '{pc: '0, instr: NOP_INSTR};

   // Sequential fetch address; wraps modulo 2^XLEN.
   function automatic logic [XLEN-1:0] next_pc(input logic [XLEN-1:0] pc);
      return pc + XLEN'(4);
   endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetched instructions. Flush wins over push/pop.
// The caller guarantees it never pushes when full or pops when empty.
module fetch_fifo
   import r200_pkg::*;
#(
   parameter int unsigned DEPTH = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush,
   input  logic                     push,
   input  if_entry_t                push_entry,
   input  logic                     pop,
   output if_entry_t                head,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   if_entry_t        mem_q [DEPTH];
   if_entry_t        mem_d [DEPTH];

   // Next-state for pointers, occupancy and storage.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      mem_d    = mem_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) begin
            mem_d[wr_ptr_q] = push_entry;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
         end
         if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
         end else if (!push && pop) begin
            count_d = count_q - CNT_W'(1);
         end
      end
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= EMPTY_ENTRY;
         end
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         mem_q    <= mem_d;
      end
   end

   assign head  = mem_q[rd_ptr_q];
   assign count = count_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues in-order imem requests under a
// credit limit, buffers responses for ID and flushes on a redirect. Responses
// already in flight at a redirect are counted in kill_q and discarded.
module fetch_stage
   import r200_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEFAULT,
   parameter int unsigned     BUF_DEPTH = 2,
   parameter int unsigned     MAX_OUTST = 2
) (
   input  logic               clk,
   input  logic               rst,
   output logic               imem_req_valid,
   input  logic               imem_req_ready,
   output logic [XLEN-1:0]    imem_req_addr,
   input  logic               imem_rsp_valid,
   input  logic [INSTR_W-1:0] imem_rsp_data,
   input  logic               id_halt,
   input  logic               redirect_valid,
   input  logic [XLEN-1:0]    redirect_pc,
   output logic               if_valid,
   output logic [XLEN-1:0]    if_pc,
   output logic [INSTR_W-1:0] if_instr
);

   localparam int unsigned CNT_W  = $clog2(BUF_DEPTH) + 1;
   localparam int unsigned KILL_W = $clog2(MAX_OUTST) + 1;

   localparam logic [CNT_W-1:0] OUTST_LIM = MAX_OUTST[CNT_W-1:0];
   localparam logic [CNT_W:0]   OCC_LIM   = BUF_DEPTH[CNT_W:0];

   logic [XLEN-1:0]   pc_q, pc_d;
   logic [XLEN-1:0]   rsp_pc_q, rsp_pc_d;
   logic [CNT_W-1:0]  outst_q, outst_d;
   logic [KILL_W-1:0] kill_q, kill_d;

   logic [XLEN-1:0]   redirect_target;
   logic              unused_redirect_lsb;
   logic [CNT_W:0]    occupancy;
   logic              req_fire;
   logic              rsp_keep;
   logic              buf_push;
   logic              buf_pop;
   if_entry_t         push_entry;
   if_entry_t         head;
   logic [CNT_W-1:0]  buf_count;

   // Targets are word aligned; the low bits are intentionally dropped.
   assign redirect_target     = {redirect_pc[XLEN-1:2], 2'b00};
   assign unused_redirect_lsb = ^redirect_pc[1:0];

   // Issue gating, response filtering and output muxing.
   always_comb begin
      // In-flight requests reserve buffer space so a response can always be pushed.
      occupancy      = {1'b0, outst_q} + {1'b0, buf_count};
      imem_req_valid = !rst && !redirect_valid && (outst_q < OUTST_LIM) && (occupancy < OCC_LIM);
      imem_req_addr  = pc_q;
      req_fire       = imem_req_valid && imem_req_ready;

      rsp_keep       = imem_rsp_valid && !redirect_valid && (kill_q == '0);
      buf_push       = rsp_keep;
      push_entry     = '{pc: rsp_pc_q, instr: imem_rsp_data};

      if_valid       = !rst && (buf_count != '0);
      if_pc          = rst ? '0 : head.pc;
      if_instr       = rst ? '0 : head.instr;
      buf_pop        = if_valid && !id_halt && !redirect_valid;
   end

   // Next-state for PC, response PC and the outstanding/kill counters.
   always_comb begin
      pc_d     = pc_q;
      rsp_pc_d = rsp_pc_q;
      outst_d  = outst_q;
      kill_d   = kill_q;

      if (req_fire) begin
         outst_d = outst_d + CNT_W'(1);
      end
      if (imem_rsp_valid) begin
         outst_d = outst_d - CNT_W'(1);
      end

      if (redirect_valid) begin
         pc_d     = redirect_target;
         rsp_pc_d = redirect_target;
         // Everything still in flight after this cycle belongs to the old path.
         kill_d   = outst_d[KILL_W-1:0];
      end else begin
         if (req_fire) begin
            pc_d = next_pc(pc_q);
         end
         if (rsp_keep) begin
            rsp_pc_d = next_pc(rsp_pc_q);
         end
         if (imem_rsp_valid && (kill_q != '0)) begin
            kill_d = kill_q - KILL_W'(1);
         end
      end
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q     <= RESET_PC;
         rsp_pc_q <= RESET_PC;
         outst_q  <= '0;
         kill_q   <= '0;
      end else begin
         pc_q     <= pc_d;
         rsp_pc_q <= rsp_pc_d;
         outst_q  <= outst_d;
         kill_q   <= kill_d;
      end
   end

   fetch_fifo #(
      .DEPTH (BUF_DEPTH)
   ) u_fifo (
      .clk        (clk),
      .rst        (rst),
      .flush      (redirect_valid),
      .push       (buf_push),
      .push_entry (push_entry),
      .pop        (buf_pop),
      .head       (head),
      .count      (buf_count)
   );

   // A response with nothing outstanding is an imem protocol violation.
   a_rsp_has_req: assert property (@(posedge clk) disable iff (rst)
      imem_rsp_valid |-> (outst_q != '0));

   a_kill_bounded: assert property (@(posedge clk) disable iff (rst)
      {{(CNT_W){1'b0}}, kill_q} <= {{(KILL_W){1'b0}}, outst_q});

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: an in-order imem model plus a queue-based model of
// the instruction stream that ID should see.
module tb_fetch_stage;

   localparam logic [31:0] RESET_PC  = 32'h0000_0000;
   localparam int unsigned BUF_DEPTH = 2;
   localparam int unsigned MAX_OUTST = 2;

   logic        clk;
   logic        rst;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        id_halt;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        if_valid;
   logic [31:0] if_pc;
   logic [31:0] if_instr;

   fetch_stage #(
      .RESET_PC  (RESET_PC),
      .BUF_DEPTH (BUF_DEPTH),
      .MAX_OUTST (MAX_OUTST)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_req_addr  (imem_req_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .id_halt        (id_halt),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .if_valid       (if_valid),
      .if_pc          (if_pc),
      .if_instr       (if_instr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct { logic [31:0] addr; int due; } pend_t;
   typedef struct { logic [31:0] pc; logic [31:0] instr; } ent_t;

   pend_t       pend_q[$];   // accepted requests not yet answered (incl. stale ones)
   ent_t        buf_q[$];    // instructions ID should see, in order
   int          m_kill;
   logic [31:0] exp_req_pc;
   logic [31:0] last_pop_pc;
   bit          have_last;
   bit          chk_redir;
   logic [31:0] redir_target;

   int          cyc;
   int          errors;
   int          checks;

   int          ready_pct;
   int          lat_min;
   int          lat_max;
   int          halt_pct;
   bit          s_rst;
   bit          s_halt;
   bit          s_redir;
   logic [31:0] s_redir_pc;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[7:0], a[31:8]} ^ 32'hC3A5_1234;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One clock cycle: drive at negedge, compare, then advance the model at posedge.
   task automatic cycle();
      bit          rsp_now;
      bit          acc;
      bit          pop;
      bit          exp_req_valid;
      bit          exp_if_valid;
      logic [31:0] acc_addr;
      pend_t       p;
      pend_t       done;
      ent_t        e;

      @(negedge clk);
      rst            = s_rst;
      id_halt        = s_halt;
      redirect_valid = s_redir;
      redirect_pc    = s_redir_pc;
      imem_req_ready = ($urandom_range(99) < ready_pct);
      rsp_now        = !s_rst && (pend_q.size() > 0) && (pend_q[0].due <= cyc);
      imem_rsp_valid = rsp_now;
      imem_rsp_data  = rsp_now ? mem_word(pend_q[0].addr) : $urandom;
      #1;

      exp_if_valid  = !s_rst && (buf_q.size() != 0);
      exp_req_valid = !s_rst && !s_redir && (pend_q.size() < MAX_OUTST)
                      && (pend_q.size() + buf_q.size() < BUF_DEPTH);
      check("if_valid", {31'b0, if_valid}, {31'b0, exp_if_valid});
      check("req_valid", {31'b0, imem_req_valid}, {31'b0, exp_req_valid});
      if (s_rst) begin
         check("rst_if_pc", if_pc, 32'h0);
         check("rst_if_instr", if_instr, 32'h0);
      end else if (exp_if_valid) begin
         check("if_pc", if_pc, buf_q[0].pc);
         check("if_instr", if_instr, buf_q[0].instr);
      end
      if (exp_req_valid) begin
         check("req_addr", imem_req_addr, exp_req_pc);
      end

      pop = exp_if_valid && !s_halt && !s_redir;
      if (pop) begin
         if (have_last) begin
            check("pc_step", if_pc, last_pop_pc + 32'd4);
         end
         if (chk_redir) begin
            check("first_after_redirect", if_pc, redir_target);
            chk_redir = 1'b0;
         end
      end
      acc      = imem_req_valid && imem_req_ready;
      acc_addr = imem_req_addr;

      @(posedge clk);
      if (s_rst) begin
         // imem is reset alongside the fetch stage
         pend_q.delete();
         buf_q.delete();
         m_kill      = 0;
         exp_req_pc  = RESET_PC;
         have_last   = 1'b0;
         chk_redir   = 1'b0;
      end else begin
         if (pop) begin
            last_pop_pc = buf_q[0].pc;
            have_last   = 1'b1;
            void'(buf_q.pop_front());
         end
         if (acc) begin
            p.addr = acc_addr;
            p.due  = cyc + int'($urandom_range(lat_max, lat_min));
            pend_q.push_back(p);
            exp_req_pc = exp_req_pc + 32'd4;
         end
         if (rsp_now) begin
            done = pend_q.pop_front();
            if (!s_redir) begin
               if (m_kill > 0) begin
                  m_kill--;
               end else begin
                  e.pc    = done.addr;
                  e.instr = mem_word(done.addr);
                  buf_q.push_back(e);
               end
            end
         end
         if (s_redir) begin
            buf_q.delete();
            m_kill       = pend_q.size();
            exp_req_pc   = s_redir_pc & ~32'h3;
            redir_target = s_redir_pc & ~32'h3;
            have_last    = 1'b0;
            chk_redir    = 1'b1;
         end
      end
      cyc++;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) begin
         cycle();
      end
   endtask

   initial begin
      bit found;
      errors = 0; checks = 0; cyc = 0;
      m_kill = 0; exp_req_pc = RESET_PC; last_pop_pc = '0;
      have_last = 1'b0; chk_redir = 1'b0; redir_target = '0;
      ready_pct = 100; lat_min = 1; lat_max = 1; halt_pct = 0;
      s_rst = 1'b1; s_halt = 1'b0; s_redir = 1'b0; s_redir_pc = '0;
      rst = 1'b1; id_halt = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
      imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;

      // Reset, then straight-line fetch with 1-cycle latency.
      run(2);
      s_rst = 1'b0;
      run(12);

      // Decode stall: head held, requests stop once the buffer is committed.
      s_halt = 1'b1;
      run(5);
      s_halt = 1'b0;
      run(8);

      // Redirect with two requests in flight.
      lat_min = 3; lat_max = 3;
      found = 1'b0;
      for (int i = 0; i < 50 && !found; i++) begin
         if (pend_q.size() == 2) found = 1'b1;
         else cycle();
      end
      check("setup_two_inflight", {31'b0, found}, 32'd1);
      s_redir = 1'b1; s_redir_pc = 32'h0000_0100;
      cycle();
      s_redir = 1'b0;
      run(15);

      // Redirect in the same cycle as a response and a would-be pop.
      lat_min = 1; lat_max = 1;
      found = 1'b0;
      for (int i = 0; i < 50 && !found; i++) begin
         if (pend_q.size() > 0 && pend_q[0].due <= cyc && buf_q.size() > 0) found = 1'b1;
         else cycle();
      end
      check("setup_rsp_pop_redirect", {31'b0, found}, 32'd1);
      s_redir = 1'b1; s_redir_pc = 32'h2000_0043;
      cycle();
      s_redir = 1'b0;
      run(10);

      // Redirect near the top of the address space to exercise PC wrap.
      s_redir = 1'b1; s_redir_pc = 32'hFFFF_FFF8;
      cycle();
      s_redir = 1'b0;
      run(12);

      // Random ready/latency/stall with occasional redirects.
      ready_pct = 30; lat_min = 1; lat_max = 3;
      for (int i = 0; i < 1500; i++) begin
         s_halt  = ($urandom_range(99) < 25);
         s_redir = ($urandom_range(99) < 3);
         s_redir_pc = $urandom;
         cycle();
      end
      s_halt = 1'b0; s_redir = 1'b0;
      ready_pct = 100;
      run(10);

      // Reset mid-stream with one request in flight.
      lat_min = 3; lat_max = 3;
      found = 1'b0;
      for (int i = 0; i < 50 && !found; i++) begin
         if (pend_q.size() == 1) found = 1'b1;
         else cycle();
      end
      check("setup_one_inflight", {31'b0, found}, 32'd1);
      s_rst = 1'b1;
      cycle();
      s_rst = 1'b0;
      cycle();
      run(12);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
